// File: rtl/ntt_pkg.sv
// ntt_pkg: constants and types shared by the NTT result path.
//   Q, N, DW, AW  : modulus, frame length, coefficient width, frame index width
//   drain_state_e : drainer FSM states
//   bitrev()      : AW-bit index reversal for bit-reversed-order frames
package ntt_pkg;
  localparam int unsigned N  = 128;
  localparam int unsigned DW = 16;
  localparam int unsigned Q  = 12289;
  localparam int unsigned AW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } drain_state_e;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction
endpackage

// File: rtl/ntt_modq_canon.sv
// ntt_modq_canon: combinational reduction of a coefficient in [0,2Q) to [0,Q).
//   x_i : coefficient in [0,2Q)
//   y_o : canonical coefficient in [0,Q)
// Inputs >= 2Q are out of contract; they get one truncated subtraction of Q.
module ntt_modq_canon
  import ntt_pkg::*;
#(
  parameter int unsigned DW = ntt_pkg::DW,
  parameter int unsigned Q  = ntt_pkg::Q
) (
  input  logic [DW-1:0] x_i,
  output logic [DW-1:0] y_o
);
  localparam logic [DW-1:0] QV = DW'(Q);

  assign y_o = (x_i >= QV) ? (x_i - QV) : x_i;
endmodule

// File: rtl/ntt_result_drainer.sv
// ntt_result_drainer: collects one frame of N NTT coefficients, reduces each
// to [0,Q), buffers the frame, then drains it into the clk2->clk3 async FIFO
// write port one word per accepted cycle under fifo_full back-pressure.
//   clk, rst_n           : clk2 clock, async active-low reset
//   in_valid/in_data     : coefficient stream from the butterfly engine
//   in_ready             : high while idle or loading
//   fifo_full            : FIFO write-side full flag
//   out_valid/out_data   : FIFO winc / wdata (registered)
//   busy                 : high until the frame is fully drained
//   frame_done           : one-cycle pulse after the last word is accepted
// Build option: NTT_DRAIN_BITREV_EN drains in bit-reversed index order so a
// bit-reversed-order NTT comes out in natural order.
module ntt_result_drainer #(
  parameter int unsigned N  = ntt_pkg::N,
  parameter int unsigned DW = ntt_pkg::DW,
  parameter int unsigned Q  = ntt_pkg::Q
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          fifo_full,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          frame_done
);
  import ntt_pkg::*;

  localparam int unsigned ADDR_W = $clog2(N);

  drain_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   ld_cnt_q, ld_cnt_d;
  // Number of words already moved into the output register this frame.
  logic [ADDR_W:0]     dr_cnt_q, dr_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DW-1:0]       out_data_q, out_data_d;
  logic                frame_done_q, frame_done_d;

  logic [DW-1:0]       mem [N];
  logic [DW-1:0]       canon;
  logic [ADDR_W-1:0]   rd_addr;
  logic                ld_fire, acc;

  ntt_modq_canon #(.DW(DW), .Q(Q)) u_canon (
    .x_i (in_data),
    .y_o (canon)
  );

  assign in_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign busy     = (state_q != S_IDLE);
  assign ld_fire  = in_valid && in_ready;
  assign acc      = out_valid_q && !fifo_full;

`ifdef NTT_DRAIN_BITREV_EN
  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < ADDR_W; i++) rd_addr[i] = dr_cnt_q[ADDR_W-1-i];
  end
`else
  assign rd_addr = dr_cnt_q[ADDR_W-1:0];
`endif

  // Frame buffer: contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (ld_fire) mem[ld_cnt_q] <= canon;
  end

  always_comb begin
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    dr_cnt_d     = dr_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (ld_fire) begin
          // ld_cnt wraps to 0 on the last word of the frame.
          ld_cnt_d = ld_cnt_q + 1'b1;
          state_d  = (ld_cnt_q == ADDR_W'(N-1)) ? S_DRAIN : S_LOAD;
        end
      end
      S_DRAIN: begin
        if (acc && (dr_cnt_q == (ADDR_W+1)'(N))) begin
          // Last word leaves this edge.
          out_valid_d  = 1'b0;
          out_data_d   = '0;
          dr_cnt_d     = '0;
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else if (acc || !out_valid_q) begin
          // Refill the output register; a full FIFO holds it instead.
          out_valid_d = 1'b1;
          out_data_d  = mem[rd_addr];
          dr_cnt_d    = dr_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ld_cnt_q     <= '0;
      dr_cnt_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_cnt_q     <= ld_cnt_d;
      dr_cnt_q     <= dr_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;
endmodule
